mainfsm: RTL and testbench
==========================

# mainfsm

Multicycle main control FSM that sequences the shared single-memory ARM datapath through fetch, decode, execute, memory and writeback steps. Sits beside the ALU decoder and condition logic in the controller; it decodes `Op`/`Funct` from the latched instruction and drives the datapath's mux selects and raw write enables every cycle. Condition gating of `RegW`/`MemW`/`Branch`/`NextPC` happens downstream of this block.

## Interface
- No parameters.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `Op` in 2: `Instr[27:26]`.
- `Funct` in 6: `Instr[25:20]`; bit 5 = I (immediate), bit 0 = L/S (load).
- `IRWrite` out 1: instruction register enable.
- `AdrSrc` out 1: memory address select; 0 = PC, 1 = Result.
- `ALUSrcA` out 2: 00 = A register, 01 = PC; 10/11 are never driven.
- `ALUSrcB` out 2: 00 = WriteData register, 01 = ExtImm, 10 = constant 4.
- `ResultSrc` out 2: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `NextPC` out 1: unconditional PC update request.
- `RegW` out 1: raw register write, before condition gating.
- `MemW` out 1: raw memory write, before condition gating.
- `Branch` out 1: raw branch, before condition gating.
- `ALUOp` out 1: 1 = ALU decoder uses `Funct`; 0 = force ADD.
- `Illegal` out 1: high while in UNKNOWN.
- `State` out 4: current state code, for debug and checking.

## Operation
- Moore machine: all outputs decode from the state register only. Unlisted outputs are 0; unlisted selects are 00.
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, UNKNOWN=10. Codes 11–15 are treated as UNKNOWN.
- Per-state outputs:
  - FETCH: AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, IRWrite=1, NextPC=1.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcA=00, ALUSrcB=01.
  - MEMRD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, ResultSrc=00, MemW=1.
  - EXECUTER: ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
  - UNKNOWN: Illegal=1; all enables 0.
- Transitions:
  - FETCH → DECODE.
  - DECODE:
    - Op=01 → MEMADR.
    - Op=00 and Funct[5]=0 → EXECUTER.
    - Op=00 and Funct[5]=1 → EXECUTEI.
    - Op=10 → BRANCH.
    - Op=11 → UNKNOWN.
  - MEMADR: Funct[0]=1 → MEMRD, else → MEMWR.
  - MEMRD → MEMWB → FETCH.
  - MEMWR → FETCH.
  - EXECUTER / EXECUTEI → ALUWB → FETCH.
  - BRANCH → FETCH.
  - UNKNOWN (and codes 11–15) → FETCH.
- `Op`/`Funct` are sampled only in DECODE and MEMADR. Changes in other states have no effect.

## Timing
- Reset: the register loads FETCH on the first rising edge with `reset`=1.
- While `reset`=1, IRWrite, NextPC, RegW, MemW, Branch and Illegal are forced 0 regardless of state. Selects show FETCH values; `State`=0.
- First cycle after `reset` falls is FETCH with IRWrite=1 and NextPC=1.
- Cycles per instruction, FETCH to FETCH:
  - data-processing: 4
  - LDR: 5
  - STR: 4
  - B: 3
  - Op=11: 3
- Reset asserted mid-instruction: the in-progress sequence is abandoned at that edge. No partial writeback occurs after the reset edge.
- Outputs are combinational from the state, so they are glitch-tolerant only. Consumers sample them at the next rising edge.

## Structure
- Shared package `arm_ctrl_pkg` holds:
  - state enum/localparams (4-bit);
  - ALUSrcA, ALUSrcB, ResultSrc and AdrSrc encodings, which the datapath muxes also use.
- State register is the existing reset flop, parameterized to 4 bits. FETCH=0 matches its reset-to-zero behavior.
- Next-state and output decode stay inline; no further sub-modules.

## Test plan
- Reset held 3 cycles, then released → `State`=0 throughout with IRWrite=0; first post-reset cycle has IRWrite=1, NextPC=1, ALUSrcB=10.
- Op=00, Funct=6'b001000 (ADD reg) → states 0,1,6,8,0; ALUOp=1 only in state 6; RegW=1 only in state 8 with ResultSrc=00.
- Op=00, Funct=6'b101000 (ADD imm) → states 0,1,7,8,0; ALUSrcB=01 in state 7.
- Op=01, Funct=6'b011001 (LDR) → states 0,1,2,3,4,0; AdrSrc=1 in state 3; RegW=1 with ResultSrc=01 in state 4.
- Op=01, Funct=6'b011000 (STR) → states 0,1,2,5,0; MemW=1 only in state 5. Then Op=10 (B) → states 0,1,9,0 with Branch=1 and ALUSrcB=01 in state 9.
- Two sub-cases:
  - Op=11 → state 10 for one cycle with Illegal=1 and no enables, then FETCH.
  - `reset` asserted during MEMRD → next state is FETCH; MEMWB is never entered and RegW is never asserted.

Source files
------------

// File: rtl/arm_ctrl_pkg.sv
// Shared controller definitions: main FSM state codes and the datapath mux
// select encodings that both the controller and the datapath muxes decode.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_UNKNOWN  = 4'd10
    } state_e;

    localparam logic       ADR_PC        = 1'b0;
    localparam logic       ADR_RESULT    = 1'b1;

    localparam logic [1:0] SRCA_REG      = 2'b00;
    localparam logic [1:0] SRCA_PC       = 2'b01;

    localparam logic [1:0] SRCB_WD       = 2'b00;
    localparam logic [1:0] SRCB_IMM      = 2'b01;
    localparam logic [1:0] SRCB_FOUR     = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

endpackage

// File: rtl/mainfsm_flopr.sv
// Resettable register with synchronous active-high reset to zero.
module mainfsm_flopr #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) q <= '0;
        else       q <= d;
    end

endmodule

// File: rtl/mainfsm.sv
// Multicycle main control FSM for the single-memory ARM datapath.
// Moore outputs; write/update enables are held low while reset is high.
//
// state    | meaning
// ---------+----------------------------------------------
// FETCH    | read instr at PC, latch IR, PC <= PC + 4
// DECODE   | read registers, ALUResult = PC + 8
// MEMADR   | compute load/store address A + ExtImm
// MEMRD    | read data memory at computed address
// MEMWB    | write loaded data to register file
// MEMWR    | write register data to memory
// EXECUTER | ALU op with register operand B
// EXECUTEI | ALU op with immediate operand
// ALUWB    | write ALU result to register file
// BRANCH   | PC <= PC + 8 + offset (if condition holds)
// UNKNOWN  | illegal opcode, flagged for one cycle
module mainfsm
    import arm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       ALUOp,
    output logic       Illegal,
    output logic [3:0] State
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic [3:0] state_eff;
    logic       unused_funct;

    logic       irwrite_raw;
    logic       nextpc_raw;
    logic       regw_raw;
    logic       memw_raw;
    logic       branch_raw;
    logic       illegal_raw;

    assign unused_funct = ^Funct[4:1];

    mainfsm_flopr #(.WIDTH(4)) u_state_reg (
        .clk   (clk),
        .reset (reset),
        .d     (state_d),
        .q     (state_q)
    );

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_DP:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_UNKNOWN;
                endcase
            end
            S_MEMADR:   state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_d = S_MEMWB;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // During reset the register may not yet hold FETCH, so decode as if it does.
    assign state_eff = reset ? 4'(S_FETCH) : state_q;

    always_comb begin
        irwrite_raw = 1'b0;
        AdrSrc      = ADR_PC;
        ALUSrcA     = SRCA_REG;
        ALUSrcB     = SRCB_WD;
        ResultSrc   = RES_ALUOUT;
        nextpc_raw  = 1'b0;
        regw_raw    = 1'b0;
        memw_raw    = 1'b0;
        branch_raw  = 1'b0;
        ALUOp       = 1'b0;
        illegal_raw = 1'b0;
        case (state_eff)
            S_FETCH: begin
                AdrSrc      = ADR_PC;
                ALUSrcA     = SRCA_PC;
                ALUSrcB     = SRCB_FOUR;
                ResultSrc   = RES_ALURESULT;
                irwrite_raw = 1'b1;
                nextpc_raw  = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_REG;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
                AdrSrc    = ADR_RESULT;
                ResultSrc = RES_ALUOUT;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                regw_raw  = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc    = ADR_RESULT;
                ResultSrc = RES_ALUOUT;
                memw_raw  = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcB = SRCB_WD;
                ALUOp   = 1'b1;
            end
            S_EXECUTEI: begin
                ALUSrcB = SRCB_IMM;
                ALUOp   = 1'b1;
            end
            S_ALUWB: begin
                ResultSrc = RES_ALUOUT;
                regw_raw  = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcB    = SRCB_IMM;
                ResultSrc  = RES_ALURESULT;
                branch_raw = 1'b1;
            end
            default: illegal_raw = 1'b1;
        endcase
    end

    assign IRWrite = irwrite_raw & ~reset;
    assign NextPC  = nextpc_raw  & ~reset;
    assign RegW    = regw_raw    & ~reset;
    assign MemW    = memw_raw    & ~reset;
    assign Branch  = branch_raw  & ~reset;
    assign Illegal = illegal_raw & ~reset;
    assign State   = state_eff;

endmodule

// File: tb/tb_mainfsm.sv
// Randomized self-checking bench for mainfsm against an instruction-level model.
module tb_mainfsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp, Illegal;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [3:0] State;

    int checks = 0;
    int errors = 0;

    mainfsm dut (
        .clk       (clk),
        .reset     (reset),
        .Op        (Op),
        .Funct     (Funct),
        .IRWrite   (IRWrite),
        .AdrSrc    (AdrSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .NextPC    (NextPC),
        .RegW      (RegW),
        .MemW      (MemW),
        .Branch    (Branch),
        .ALUOp     (ALUOp),
        .Illegal   (Illegal),
        .State     (State)
    );

    always #5 clk = ~clk;

    // Output vector: {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, Branch, ALUOp, Illegal}
    function automatic logic [13:0] dut_out();
        return {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, Branch, ALUOp, Illegal};
    endfunction

    // Reference per-state output table written straight from the state descriptions.
    function automatic logic [13:0] ref_out(int st);
        logic       irw = 0, adr = 0, npc = 0, rw = 0, mw = 0, br = 0, aop = 0, ill = 0;
        logic [1:0] sa = 2'b00, sb = 2'b00, rs = 2'b00;
        case (st)
            0:  begin sa = 2'b01; sb = 2'b10; rs = 2'b10; irw = 1; npc = 1; end
            1:  begin sa = 2'b01; sb = 2'b10; rs = 2'b10; end
            2:  begin sb = 2'b01; end
            3:  begin adr = 1; end
            4:  begin rs = 2'b01; rw = 1; end
            5:  begin adr = 1; mw = 1; end
            6:  begin aop = 1; end
            7:  begin sb = 2'b01; aop = 1; end
            8:  begin rw = 1; end
            9:  begin sb = 2'b01; rs = 2'b10; br = 1; end
            default: ill = 1;
        endcase
        return {irw, adr, sa, sb, rs, npc, rw, mw, br, aop, ill};
    endfunction

    // Instruction-level model: the full FETCH-to-FETCH state sequence for one instruction.
    function automatic void ref_seq(input logic [1:0] op, input logic [5:0] fn, output int seq[$]);
        seq = {};
        seq.push_back(0);
        seq.push_back(1);
        if (op == 2'b01)      begin seq.push_back(2); if (fn[0]) begin seq.push_back(3); seq.push_back(4); end else seq.push_back(5); end
        else if (op == 2'b00) begin seq.push_back(fn[5] ? 7 : 6); seq.push_back(8); end
        else if (op == 2'b10) seq.push_back(9);
        else                  seq.push_back(10);
    endfunction

    function automatic int ref_cpi(input logic [1:0] op, input logic [5:0] fn);
        if (op == 2'b01) return fn[0] ? 5 : 4;
        if (op == 2'b00) return 4;
        return 3;
    endfunction

    // Drives one instruction from FETCH back to FETCH; junk on Op/Funct outside sampling states.
    task automatic run_instr(input logic [1:0] op, input logic [5:0] fn, input string name);
        int seq[$];
        ref_seq(op, fn, seq);
        checks++;
        if (seq.size() !== ref_cpi(op, fn)) begin
            errors++;
            $display("FAIL %s cpi: model %0d required %0d", name, seq.size(), ref_cpi(op, fn));
        end
        foreach (seq[i]) begin
            if (seq[i] == 1 || seq[i] == 2) begin Op = op; Funct = fn; end
            else begin Op = 2'($urandom); Funct = 6'($urandom); end
            @(negedge clk);
            checks++;
            if (State !== 4'(seq[i])) begin
                errors++;
                $display("FAIL %s state[%0d]: got %0d required %0d", name, i, State, seq[i]);
            end
            checks++;
            if (dut_out() !== ref_out(seq[i])) begin
                errors++;
                $display("FAIL %s outputs st%0d: got %b required %b", name, seq[i], dut_out(), ref_out(seq[i]));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic check_reset_cycle(input string name);
        @(negedge clk);
        checks++;
        if (State !== 4'd0) begin
            errors++;
            $display("FAIL %s state: got %0d required 0", name, State);
        end
        checks++;
        if (dut_out() !== (ref_out(0) & 14'b11_1111_1100_0000 & ~14'b10_0000_0000_0000)) begin
            errors++;
            $display("FAIL %s outputs: got %b required %b", name, dut_out(),
                     ref_out(0) & 14'b11_1111_1100_0000 & ~14'b10_0000_0000_0000);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; Op = 2'b00; Funct = 6'd0;
        for (int i = 0; i < 3; i++) begin
            check_reset_cycle("reset_hold");
            @(posedge clk); #1;
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (State !== 4'd0 || IRWrite !== 1'b1 || NextPC !== 1'b1 || ALUSrcB !== 2'b10) begin
            errors++;
            $display("FAIL first_fetch: got st=%0d irw=%b npc=%b srcb=%b required st=0 irw=1 npc=1 srcb=10",
                     State, IRWrite, NextPC, ALUSrcB);
        end
        @(posedge clk); #1;
        // Finish the instruction that has started fetching (treated as ADD reg).
        Op = 2'b00; Funct = 6'b001000;
        for (int i = 1; i < 4; i++) begin @(posedge clk); #1; end
    endtask

    task automatic test_directed();
        run_instr(2'b00, 6'b001000, "add_reg");
        run_instr(2'b00, 6'b101000, "add_imm");
        run_instr(2'b01, 6'b011001, "ldr");
        run_instr(2'b01, 6'b011000, "str");
        run_instr(2'b10, 6'b000000, "branch");
    endtask

    task automatic test_illegal();
        run_instr(2'b11, 6'b000000, "illegal");
        run_instr(2'b11, 6'b111111, "illegal2");
        run_instr(2'b00, 6'b001000, "after_illegal");
    endtask

    task automatic test_reset_midinstr();
        int seq[$];
        ref_seq(2'b01, 6'b011001, seq);
        for (int i = 0; i < 4; i++) begin
            if (seq[i] == 1 || seq[i] == 2) begin Op = 2'b01; Funct = 6'b011001; end
            @(negedge clk);
            checks++;
            if (State !== 4'(seq[i])) begin
                errors++;
                $display("FAIL rst_mid pre state[%0d]: got %0d required %0d", i, State, seq[i]);
            end
            if (i < 3) begin @(posedge clk); #1; end
        end
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_cycle("rst_mid");
        checks++;
        if (RegW !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid regw: got %b required 0", RegW);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        run_instr(2'b10, 6'b000000, "rst_mid_resume");
    endtask

    task automatic test_random();
        logic [1:0] op;
        logic [5:0] fn;
        for (int n = 0; n < 120; n++) begin
            op = 2'($urandom);
            fn = 6'($urandom);
            run_instr(op, fn, "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_illegal();
        test_reset_midinstr();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
